// File: rtl/cdm8_err_acc_if.sv
// Sample/result bundle between a stimulus source (master) and the error accumulator (slave).
interface cdm8_err_acc_if #(
  parameter int W = 8
);
  logic               start;
  logic               in_valid;
  logic               in_ready;
  logic [W-1:0]       A;
  logic [W-1:0]       B;
  logic [2*W-1:0]     R;
  logic               busy;
  logic               done;
  logic [2*W:0]       sample_count;
  logic [2*W:0]       err_count;
  logic [4*W-1:0]     sum_ed;
  logic [2*W-1:0]     max_ed;

  modport master (
    output start, in_valid, A, B, R,
    input  in_ready, busy, done, sample_count, err_count, sum_ed, max_ed
  );

  modport slave (
    input  start, in_valid, A, B, R,
    output in_ready, busy, done, sample_count, err_count, sum_ed, max_ed
  );
endinterface

// File: rtl/cdm8_err_acc.sv
// Streaming error-metric accumulator: compares an approximate product R against the exact A*B
// and accumulates mismatch count, summed error distance and max error distance per sweep.
module cdm8_err_acc #(
  parameter int W         = 8,
  parameter int N_SAMPLES = 65536
) (
  input  logic               clk,
  input  logic               rst,
  cdm8_err_acc_if.slave      bus
);
  localparam int PW = 2 * W;
  localparam int CW = 2 * W + 1;
  localparam int SW = 4 * W;
  localparam logic [CW-1:0] LAST_CNT = CW'(N_SAMPLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  state_t state_q, state_d;

  logic in_ready_c, busy_c, done_c, clear_c, accept_c;

  logic          s1_valid_q;
  logic [W-1:0]  s1_a_q, s1_b_q;
  logic [PW-1:0] s1_r_q;

  logic          s2_valid_q, s2_mis_q;
  logic [PW-1:0] s2_ed_q;

  logic [CW-1:0] sample_count_q, err_count_q;
  logic [SW-1:0] sum_ed_q;
  logic [PW-1:0] max_ed_q;

  logic [PW-1:0] exact_c;
  logic [CW-1:0] diff_c;
  logic [PW-1:0] ed_c;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    in_ready_c = 1'b0;
    busy_c     = 1'b0;
    done_c     = 1'b0;
    clear_c    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d = ST_RUN;
          clear_c = 1'b1;
        end
      end
      ST_RUN: begin
        in_ready_c = 1'b1;
        busy_c     = 1'b1;
        if (bus.in_valid && (sample_count_q == LAST_CNT)) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        busy_c = 1'b1;
        // Once S1 is empty, the next edge moves S2's last sample into the accumulators.
        if (!s1_valid_q) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        done_c = 1'b1;
        if (bus.start) begin
          state_d = ST_RUN;
          clear_c = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign accept_c = in_ready_c & bus.in_valid;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_a_q     <= '0;
      s1_b_q     <= '0;
      s1_r_q     <= '0;
    end else begin
      s1_valid_q <= accept_c;
      if (accept_c) begin
        s1_a_q <= bus.A;
        s1_b_q <= bus.B;
        s1_r_q <= bus.R;
      end
    end
  end

  // Signed difference carries one extra bit; its sign selects which way round to subtract.
  assign exact_c = PW'(s1_a_q) * PW'(s1_b_q);
  assign diff_c  = {1'b0, exact_c} - {1'b0, s1_r_q};
  assign ed_c    = diff_c[CW-1] ? (s1_r_q - exact_c) : diff_c[PW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      s2_mis_q   <= 1'b0;
      s2_ed_q    <= '0;
    end else begin
      s2_valid_q <= s1_valid_q;
      s2_mis_q   <= (ed_c != '0);
      s2_ed_q    <= ed_c;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_count_q <= '0;
      err_count_q    <= '0;
      sum_ed_q       <= '0;
      max_ed_q       <= '0;
    end else if (clear_c) begin
      sample_count_q <= '0;
      err_count_q    <= '0;
      sum_ed_q       <= '0;
      max_ed_q       <= '0;
    end else begin
      if (accept_c) begin
        sample_count_q <= sample_count_q + CW'(1);
      end
      if (s2_valid_q) begin
        err_count_q <= err_count_q + CW'(s2_mis_q);
        sum_ed_q    <= sum_ed_q + SW'(s2_ed_q);
        if (s2_ed_q > max_ed_q) begin
          max_ed_q <= s2_ed_q;
        end
      end
    end
  end

  assign bus.in_ready     = in_ready_c;
  assign bus.busy         = busy_c;
  assign bus.done         = done_c;
  assign bus.sample_count = sample_count_q;
  assign bus.err_count    = err_count_q;
  assign bus.sum_ed       = sum_ed_q;
  assign bus.max_ed       = max_ed_q;
endmodule

// File: tb/tb_cdm8_err_acc.sv
// Randomized and directed sweeps of cdm8_err_acc checked against a behavioural error model.
module tb_cdm8_err_acc;
  localparam int W = 8;
  localparam int N = 128;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_bad;

  longint m_cnt, m_err, m_sum, m_max;

  cdm8_err_acc_if #(.W(W)) bus ();

  cdm8_err_acc #(.W(W), .N_SAMPLES(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Carry-disregard product: partial products summed bitwise with carries thrown away.
  function automatic logic [15:0] cdm(input logic [7:0] a, input logic [7:0] b);
    logic [15:0] acc;
    acc = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) acc = acc ^ (16'(a) << i);
    end
    return acc;
  endfunction

  task automatic model_clear();
    m_cnt = 0; m_err = 0; m_sum = 0; m_max = 0;
  endtask

  task automatic model_add(input int a, input int b, input int r);
    longint ex, ed;
    ex = longint'(a) * longint'(b);
    ed = (ex > r) ? ex - r : r - ex;
    m_cnt++;
    if (ed != 0) m_err++;
    m_sum += ed;
    if (ed > m_max) m_max = ed;
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_count"}, 64'(bus.sample_count), 64'(m_cnt));
    chk({tag, "_err"},   64'(bus.err_count),    64'(m_err));
    chk({tag, "_sum"},   64'(bus.sum_ed),       64'(m_sum));
    chk({tag, "_max"},   64'(bus.max_ed),       64'(m_max));
  endtask

  // mode: 0 random errors, 1 carry-disregard products, 2 gapped random, 3/4 directed, 5 exact
  task automatic run_sweep(input int mode, input bit poke_start);
    int da[4];
    int db[4];
    int dr[4];
    int idx, cyc, a, b, r;
    bit v;
    da = '{3, 255, 2, 7};
    db = '{5, 255, 2, 7};
    dr = '{15, 0, 4, 48};
    if (mode == 4) dr[3] = 50;

    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    model_clear();
    chk("start_ready", 64'(bus.in_ready), 64'd1);
    chk("start_busy",  64'(bus.busy),     64'd1);
    chk("start_done",  64'(bus.done),     64'd0);
    check_results("start");

    idx = 0;
    cyc = 0;
    while (idx < N && cyc < 2000) begin
      v = (mode == 2) ? (cyc % 3 == 0) : 1'b1;
      a = int'($urandom_range(255));
      b = int'($urandom_range(255));
      r = a * b;
      if ((mode == 3 || mode == 4) && idx < 4) begin
        a = da[idx]; b = db[idx]; r = dr[idx];
      end else if (mode == 1) begin
        r = int'(cdm(8'(a), 8'(b)));
      end else if ((mode == 0 || mode == 2) && $urandom_range(3) == 0) begin
        r = int'($urandom_range(65535));
      end
      bus.in_valid = v;
      bus.A        = 8'(a);
      bus.B        = 8'(b);
      bus.R        = 16'(r);
      bus.start    = poke_start && (cyc == 5);
      chk("ready_run", 64'(bus.in_ready), 64'd1);
      step();
      bus.start = 1'b0;
      cyc++;
      if (v) begin
        model_add(a, b, r);
        idx++;
      end
      chk("sample_count", 64'(bus.sample_count), 64'(idx));
    end
    if (idx < N) chk("sweep_timeout", 64'(idx), 64'(N));

    bus.in_valid = 1'b1;
    bus.start    = poke_start;
    chk("ready_drop", 64'(bus.in_ready), 64'd0);
    chk("drain_busy", 64'(bus.busy),     64'd1);
    chk("drain_done", 64'(bus.done),     64'd0);
    step();
    bus.start = 1'b0;
    chk("done_early", 64'(bus.done), 64'd0);
    chk("drain_busy2", 64'(bus.busy), 64'd1);
    step();
    bus.in_valid = 1'b0;
    chk("done_set",  64'(bus.done),     64'd1);
    chk("done_busy", 64'(bus.busy),     64'd0);
    chk("done_ready", 64'(bus.in_ready), 64'd0);
    chk("done_count", 64'(bus.sample_count), 64'(N));
    check_results("final");
    if (mode == 3 || mode == 4) begin
      chk("dir_err", 64'(bus.err_count), 64'd2);
      chk("dir_sum", 64'(bus.sum_ed),    64'd65026);
      chk("dir_max", 64'(bus.max_ed),    64'd65025);
    end
    $display("sweep mode=%0d samples=%0d err=%0d sum=%0d max=%0d",
             mode, bus.sample_count, bus.err_count, bus.sum_ed, bus.max_ed);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.in_valid = 1'b0;
    bus.A = '0;
    bus.B = '0;
    bus.R = '0;
    #1 rst = 1'b1;
    #2;
    model_clear();
    chk("rst_ready", 64'(bus.in_ready), 64'd0);
    chk("rst_busy",  64'(bus.busy),     64'd0);
    chk("rst_done",  64'(bus.done),     64'd0);
    check_results("rst");
    step();
    step();
    rst = 1'b0;
    step();

    run_sweep(3, 1'b0);
    run_sweep(4, 1'b1);
    run_sweep(0, 1'b0);
    run_sweep(2, 1'b1);
    run_sweep(1, 1'b0);
    run_sweep(5, 1'b0);

    // Abort a sweep with an asynchronous reset mid-cycle.
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    for (int i = 0; i < 100; i++) begin
      bus.in_valid = 1'b1;
      bus.A = 8'($urandom_range(255));
      bus.B = 8'($urandom_range(255));
      bus.R = 16'($urandom_range(65535));
      step();
    end
    chk("pre_rst_count", 64'(bus.sample_count), 64'd100);
    #3 rst = 1'b1;
    #1;
    model_clear();
    chk("arst_ready", 64'(bus.in_ready), 64'd0);
    chk("arst_busy",  64'(bus.busy),     64'd0);
    chk("arst_done",  64'(bus.done),     64'd0);
    check_results("arst");
    bus.in_valid = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk("post_rst_ready", 64'(bus.in_ready), 64'd0);
    $display("reset mid-sweep: outputs cleared");
    run_sweep(0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
